// File: rtl/mvm_backward.sv
// Tiled signed matrix-vector product for the backprop path; optional MVM_BACKWARD_ROUND_EN rounds half up before saturation.
// valid rises P*(K+1)+1 edges after start is sampled; no backpressure, start is ignored unless idle.
module mvm_backward #(
  parameter int MATRIX_WIDTH      = 4,
  parameter int MATRIX_HEIGHT     = 5,
  parameter int VECTOR_CELL_WIDTH = 8,
  parameter int MATRIX_CELL_WIDTH = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int FRACTION          = 4,
  parameter int TILING_ROW        = 3,
  parameter int TILING_COL        = 3
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic                                                     start,
  input  logic [MATRIX_WIDTH*VECTOR_CELL_WIDTH-1:0]                vector,
  input  logic [MATRIX_WIDTH*MATRIX_HEIGHT*MATRIX_CELL_WIDTH-1:0]  matrix,
  output logic [MATRIX_HEIGHT*RESULT_CELL_WIDTH-1:0]               result,
  output logic                                                     valid,
  output logic                                                     busy,
  output logic                                                     error
);

  localparam int P     = (MATRIX_HEIGHT + TILING_ROW - 1) / TILING_ROW;
  localparam int K     = (MATRIX_WIDTH + TILING_COL - 1) / TILING_COL;
  localparam int PW    = (P > 1) ? $clog2(P) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int PRODW = VECTOR_CELL_WIDTH + MATRIX_CELL_WIDTH;
  localparam int ACCW  = PRODW + $clog2(MATRIX_WIDTH) + 1;
  localparam int VW    = MATRIX_WIDTH * VECTOR_CELL_WIDTH;
  localparam int MW    = MATRIX_WIDTH * MATRIX_HEIGHT * MATRIX_CELL_WIDTH;
  localparam int RW    = MATRIX_HEIGHT * RESULT_CELL_WIDTH;

  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(2 ** (RESULT_CELL_WIDTH - 1) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;
`ifdef MVM_BACKWARD_ROUND_EN
  localparam logic signed [ACCW-1:0] RND = ACCW'(2 ** (FRACTION - 1));
`else
  localparam logic signed [ACCW-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_WRITE, S_DONE} state_t;

  // Out-of-range rows/columns map to cell 0 so every select stays in bounds; callers mask them.
  function automatic int mat_idx(input int r, input int c);
    return (r < MATRIX_HEIGHT && c < MATRIX_WIDTH) ? (r * MATRIX_WIDTH + c) : 0;
  endfunction

  function automatic int col_idx(input int c);
    return (c < MATRIX_WIDTH) ? c : 0;
  endfunction

  function automatic int row_idx(input int r);
    return (r < MATRIX_HEIGHT) ? r : 0;
  endfunction

  state_t                  state_q, state_d;
  logic [PW-1:0]           pass_q, pass_d;
  logic [KW-1:0]           chunk_q, chunk_d;
  logic [VW-1:0]           vec_q, vec_d;
  logic [MW-1:0]           mat_q, mat_d;
  logic [RW-1:0]           result_q, result_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    error_q, error_d;
  logic signed [ACCW-1:0]  acc_q [TILING_ROW];
  logic signed [ACCW-1:0]  acc_d [TILING_ROW];

  logic                    accept, acc_en, wr_en, fin;
  logic signed [MATRIX_CELL_WIDTH-1:0] mat_op [TILING_ROW][TILING_COL];
  logic signed [VECTOR_CELL_WIDTH-1:0] vec_op [TILING_ROW][TILING_COL];
  logic signed [ACCW-1:0]  lane_sum [TILING_ROW];
  logic signed [ACCW-1:0]  rnd, shf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pass_q   <= '0;
      chunk_q  <= '0;
      vec_q    <= '0;
      mat_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
      for (int i = 0; i < TILING_ROW; i++) acc_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      chunk_q  <= chunk_d;
      vec_q    <= vec_d;
      mat_q    <= mat_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
      for (int i = 0; i < TILING_ROW; i++) acc_q[i] <= acc_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ACCUM;
      S_ACCUM: if (chunk_q == KW'(K - 1)) state_d = S_WRITE;
      S_WRITE: state_d = (pass_q == PW'(P - 1)) ? S_DONE : S_ACCUM;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept = (state_q == S_IDLE) && start;
    acc_en = (state_q == S_ACCUM);
    wr_en  = (state_q == S_WRITE);
    fin    = (state_q == S_DONE);
  end

  // Operand steering: lane i sees row pass*TILING_ROW+i, columns of chunk k; padding reads as zero.
  always_comb begin
    for (int i = 0; i < TILING_ROW; i++) begin
      for (int j = 0; j < TILING_COL; j++) begin
        mat_op[i][j] = '0;
        vec_op[i][j] = '0;
      end
    end
    for (int p = 0; p < P; p++) begin
      for (int k = 0; k < K; k++) begin
        for (int i = 0; i < TILING_ROW; i++) begin
          for (int j = 0; j < TILING_COL; j++) begin
            if (pass_q == PW'(p) && chunk_q == KW'(k) &&
                (p * TILING_ROW + i) < MATRIX_HEIGHT && (k * TILING_COL + j) < MATRIX_WIDTH) begin
              mat_op[i][j] = mat_q[mat_idx(p * TILING_ROW + i, k * TILING_COL + j) * MATRIX_CELL_WIDTH +: MATRIX_CELL_WIDTH];
              vec_op[i][j] = vec_q[col_idx(k * TILING_COL + j) * VECTOR_CELL_WIDTH +: VECTOR_CELL_WIDTH];
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < TILING_ROW; i++) begin
      lane_sum[i] = '0;
      for (int j = 0; j < TILING_COL; j++) begin
        lane_sum[i] = lane_sum[i] + ACCW'(PRODW'(mat_op[i][j]) * PRODW'(vec_op[i][j]));
      end
    end
  end

  always_comb begin
    vec_d    = vec_q;
    mat_d    = mat_q;
    result_d = result_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    error_d  = error_q;
    pass_d   = pass_q;
    chunk_d  = chunk_q;
    acc_d    = acc_q;
    rnd      = '0;
    shf      = '0;

    if (accept) begin
      vec_d    = vector;
      mat_d    = matrix;
      result_d = '0;
      valid_d  = 1'b0;
      error_d  = 1'b0;
      busy_d   = 1'b1;
      pass_d   = '0;
      chunk_d  = '0;
      for (int i = 0; i < TILING_ROW; i++) acc_d[i] = '0;
    end

    if (acc_en) begin
      for (int i = 0; i < TILING_ROW; i++) acc_d[i] = acc_q[i] + lane_sum[i];
      chunk_d = (chunk_q == KW'(K - 1)) ? '0 : chunk_q + KW'(1);
    end

    if (wr_en) begin
      for (int p = 0; p < P; p++) begin
        for (int i = 0; i < TILING_ROW; i++) begin
          if (pass_q == PW'(p) && (p * TILING_ROW + i) < MATRIX_HEIGHT) begin
            rnd = acc_q[i] + RND;
            shf = rnd >>> FRACTION;
            if (shf > SAT_MAX) begin
              result_d[row_idx(p * TILING_ROW + i) * RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] = SAT_MAX[RESULT_CELL_WIDTH-1:0];
              error_d = 1'b1;
            end else if (shf < SAT_MIN) begin
              result_d[row_idx(p * TILING_ROW + i) * RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] = SAT_MIN[RESULT_CELL_WIDTH-1:0];
              error_d = 1'b1;
            end else begin
              result_d[row_idx(p * TILING_ROW + i) * RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] = shf[RESULT_CELL_WIDTH-1:0];
            end
          end
        end
      end
      for (int i = 0; i < TILING_ROW; i++) acc_d[i] = '0;
      pass_d = (pass_q == PW'(P - 1)) ? '0 : pass_q + PW'(1);
    end

    if (fin) begin
      valid_d = 1'b1;
      busy_d  = 1'b0;
    end
  end

  assign result = result_q;
  assign valid  = valid_q;
  assign busy   = busy_q;
  assign error  = error_q;

endmodule
